// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, FSM state and control-output bundle for the pipeline controller
package cpu_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    typedef enum logic {
        ST_RUN        = 1'b0,
        ST_REDIR_PEND = 1'b1
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic pc_load;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '{
        pc_en:       1'b1,
        pc_load:     1'b0,
        ifid_en:     1'b1,
        ifid_flush:  1'b0,
        idex_en:     1'b1,
        idex_flush:  1'b0,
        exmem_en:    1'b1,
        memwb_flush: 1'b0
    };

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard inputs, stage controls and counters between pipeline and controller
interface pipeline_ctrl_if import cpu_pkg::*; ();

    logic             load_use_stall;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic             imem_ready;
    logic             dmem_busy;
    logic             cnt_clr;

    logic             pc_en;
    logic             pc_load;
    logic [XLEN-1:0]  pc_target;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             memwb_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output load_use_stall, redirect, redirect_pc, imem_ready, dmem_busy, cnt_clr,
        input  pc_en, pc_load, pc_target, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, memwb_flush, stall_cnt, flush_cnt
    );

    modport slave (
        input  load_use_stall, redirect, redirect_pc, imem_ready, dmem_busy, cnt_clr,
        output pc_en, pc_load, pc_target, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, memwb_flush, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear that wins over increment
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_max;

    assign w_at_max = &r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_at_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard/redirect controller: stage enables, bubbles, PC redirect and perf counters
module pipeline_ctrl import cpu_pkg::*; (
    input  logic          clk,
    input  logic          rst_n,
    pipeline_ctrl_if.slave bus
);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [XLEN-1:0] r_pend_pc;
    logic [XLEN-1:0] w_pend_nxt;
    logic [XLEN-1:0] w_target;
    ctrl_t           w_ctrl;
    logic            w_stall_inc;
    logic            w_flush_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_pend_pc <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pend_pc <= w_pend_nxt;
        end
    end

    always_comb begin
        w_ctrl      = CTRL_DEFAULT;
        w_target    = r_pend_pc;
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend_pc;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;

        // A data-memory wait freezes everything, including any pending redirect.
        if (bus.dmem_busy) begin
            w_ctrl.pc_en       = 1'b0;
            w_ctrl.ifid_en     = 1'b0;
            w_ctrl.idex_en     = 1'b0;
            w_ctrl.exmem_en    = 1'b0;
            w_ctrl.memwb_flush = 1'b1;
            w_stall_inc        = (r_state == ST_RUN);
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (bus.redirect) begin
                        w_ctrl.ifid_flush = 1'b1;
                        w_ctrl.idex_flush = 1'b1;
                        w_flush_inc       = 1'b1;
                        if (bus.imem_ready) begin
                            w_ctrl.pc_load = 1'b1;
                            w_target       = bus.redirect_pc;
                        end else begin
                            w_ctrl.pc_en = 1'b0;
                            w_pend_nxt   = bus.redirect_pc;
                            w_state_nxt  = ST_REDIR_PEND;
                        end
                    end else if (bus.load_use_stall) begin
                        w_ctrl.pc_en      = 1'b0;
                        w_ctrl.ifid_en    = 1'b0;
                        w_ctrl.idex_flush = 1'b1;
                        w_stall_inc       = 1'b1;
                    end else if (!bus.imem_ready) begin
                        w_ctrl.pc_en      = 1'b0;
                        w_ctrl.ifid_flush = 1'b1;
                    end
                end

                ST_REDIR_PEND: begin
                    w_ctrl.ifid_flush = 1'b1;
                    if (bus.redirect) begin
                        w_ctrl.idex_flush = 1'b1;
                        w_pend_nxt        = bus.redirect_pc;
                        w_flush_inc       = 1'b1;
                    end
                    if (!bus.imem_ready) begin
                        w_ctrl.pc_en = 1'b0;
                    end else begin
                        w_ctrl.pc_load = 1'b1;
                        w_target       = bus.redirect ? bus.redirect_pc : r_pend_pc;
                        w_state_nxt    = ST_RUN;
                    end
                end

                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // Controls read as idle for the whole time reset is held.
    assign bus.pc_en       = rst_n & w_ctrl.pc_en;
    assign bus.pc_load     = rst_n & w_ctrl.pc_load;
    assign bus.ifid_en     = rst_n & w_ctrl.ifid_en;
    assign bus.ifid_flush  = rst_n & w_ctrl.ifid_flush;
    assign bus.idex_en     = rst_n & w_ctrl.idex_en;
    assign bus.idex_flush  = rst_n & w_ctrl.idex_flush;
    assign bus.exmem_en    = rst_n & w_ctrl.exmem_en;
    assign bus.memwb_flush = rst_n & w_ctrl.memwb_flush;
    assign bus.pc_target   = rst_n ? w_target : '0;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_stall_inc),
        .i_clr (bus.cnt_clr),
        .o_cnt (bus.stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_flush_inc),
        .i_clr (bus.cnt_clr),
        .o_cnt (bus.flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl with directed and random stimulus
module tb_pipeline_ctrl;
    import cpu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_ctrl_if bus ();

    pipeline_ctrl u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]  ctrl;
        logic [31:0] tgt;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    bit          m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_scnt;
    logic [31:0] m_fcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive_cycle(input bit rst, input bit lus, input bit red,
                               input logic [31:0] rpc, input bit imem,
                               input bit busy, input bit clr);
        exp_t e;
        bit run, stall_hit, go;
        @(posedge clk);
        #1;
        rst_n              = !rst;
        bus.load_use_stall = lus;
        bus.redirect       = red;
        bus.redirect_pc    = rpc;
        bus.imem_ready     = imem;
        bus.dmem_busy      = busy;
        bus.cnt_clr        = clr;
        if (rst) begin
            m_pend = 0; m_pend_pc = '0; m_scnt = '0; m_fcnt = '0;
            e.ctrl = '0; e.tgt = '0; e.scnt = '0; e.fcnt = '0;
        end else begin
            run = !m_pend;
            go  = !busy;
            // {pc_en, pc_load, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}
            e.ctrl[7] = go && imem && !(run && !red && lus);
            e.ctrl[6] = go && imem && (m_pend || red);
            e.ctrl[5] = go && !(run && !red && lus);
            e.ctrl[4] = go && (m_pend || red || (!lus && !imem));
            e.ctrl[3] = go;
            e.ctrl[2] = go && (red || (run && lus));
            e.ctrl[1] = go;
            e.ctrl[0] = busy;
            e.tgt     = (go && red && imem) ? rpc : m_pend_pc;
            e.scnt    = m_scnt;
            e.fcnt    = m_fcnt;
            stall_hit = run && (busy || (!red && lus));
            if (go && red && (m_pend || !imem)) m_pend_pc = rpc;
            if (go) m_pend = m_pend ? !imem : (red && !imem);
            if (clr) m_scnt = '0;
            else if (stall_hit && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
            if (clr) m_fcnt = '0;
            else if (go && red && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
        end
        q_exp.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 32'h0, 1, 0, 0);
    endtask

    task automatic preload_stall(input logic [31:0] v);
        @(negedge clk);
        #2;
        force u_dut.u_stall_cnt.r_cnt = v;
        #1;
        release u_dut.u_stall_cnt.r_cnt;
        m_scnt = v;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                check("ctrl", {24'h0, bus.pc_en, bus.pc_load, bus.ifid_en, bus.ifid_flush,
                               bus.idex_en, bus.idex_flush, bus.exmem_en, bus.memwb_flush},
                      {24'h0, e.ctrl});
                check("pc_target", bus.pc_target, e.tgt);
                check("stall_cnt", bus.stall_cnt, e.scnt);
                check("flush_cnt", bus.flush_cnt, e.fcnt);
            end
        end
    end

    initial begin
        int wait_cyc;
        bus.load_use_stall = 0; bus.redirect = 0; bus.redirect_pc = '0;
        bus.imem_ready = 0; bus.dmem_busy = 0; bus.cnt_clr = 0;
        m_pend = 0; m_pend_pc = '0; m_scnt = '0; m_fcnt = '0;

        drive_cycle(1, 0, 0, 32'h0, 0, 0, 0);
        drive_cycle(1, 1, 1, 32'hABCD, 1, 1, 0);
        idle(2);

        // load-use for one cycle
        drive_cycle(0, 1, 0, 32'h0, 1, 0, 0);
        idle(1);

        // redirect with fetch ready
        drive_cycle(0, 0, 1, 32'h0000_0100, 1, 0, 0);
        idle(1);

        // redirect while fetch not ready, resolved four cycles later
        drive_cycle(0, 0, 1, 32'h0000_0200, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive_cycle(0, 1, 0, 32'h0, 0, 0, 0);
        drive_cycle(0, 0, 0, 32'h0, 1, 0, 0);
        idle(1);

        // memory wait masks redirect and load-use
        for (int i = 0; i < 5; i++) drive_cycle(0, 1, 1, 32'hDEAD_0000, 1, 1, 0);
        idle(1);

        // newest target wins while pending
        drive_cycle(0, 0, 1, 32'h0000_0400, 0, 0, 0);
        drive_cycle(0, 0, 1, 32'h0000_0500, 0, 0, 0);
        drive_cycle(0, 0, 1, 32'h0000_0600, 1, 0, 0);
        idle(1);

        // saturation then clear beats increment
        preload_stall(32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) drive_cycle(0, 1, 0, 32'h0, 1, 0, 0);
        drive_cycle(0, 1, 0, 32'h0, 1, 0, 1);
        idle(1);

        // reset while a redirect is pending
        drive_cycle(0, 0, 1, 32'h0000_0300, 0, 0, 0);
        drive_cycle(0, 0, 0, 32'h0, 0, 0, 0);
        drive_cycle(1, 0, 0, 32'h0, 1, 0, 0);
        drive_cycle(1, 1, 1, 32'h0000_0700, 0, 1, 0);
        drive_cycle(0, 0, 0, 32'h0, 1, 0, 0);
        drive_cycle(0, 0, 0, 32'h0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            drive_cycle(($urandom % 300) == 0,
                        ($urandom % 4) == 0,
                        ($urandom % 5) == 0,
                        $urandom,
                        ($urandom % 4) != 0,
                        ($urandom % 6) == 0,
                        ($urandom % 60) == 0);
        end
        idle(2);

        wait_cyc = 0;
        while (q_exp.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        check("scoreboard_drained", q_exp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
